mux_41: RTL and testbench

Registered 4-to-1 multiplexer with a two-bit select split across `s0` (LSB) and `s1` (MSB). It sits in the datapath as a synchronous steering element: it selects one of four equal-width operands each enabled clock cycle and presents the choice on a registered output. Default width is 1 bit, which matches the scalar use in existing test benches.

---
 rtl/mux_41.sv | 104 ++++++++++
 tb/tb_mux_41.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mux_41.sv
// mux_41 -- registered 4-to-1 multiplexer.
// The select code is {s1, s0}, with s1 as the MSB.
// The operand, the select code and a valid flag are captured together on
// each enabled rising edge, so all outputs change one cycle after sampling.
// Optional feature macro: MUX41_SEL_CHANGE_CNT_EN. When it is defined, a
// saturating 8-bit counter tracks how often the select code changes. When it
// is undefined, sel_changes is tied to zero.

module mux_41 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic [1:0]       sel_q,
    output logic [7:0]       sel_changes
);

    // Steering function. All four codes are legal. The default arm is
    // unreachable for 2-state select inputs and only keeps the decode total.
    function automatic logic [WIDTH-1:0] select_operand(
        input logic [1:0]       code,
        input logic [WIDTH-1:0] op_a,
        input logic [WIDTH-1:0] op_b,
        input logic [WIDTH-1:0] op_c,
        input logic [WIDTH-1:0] op_d
    );
        logic [WIDTH-1:0] result;
        case (code)
            2'b00:   result = op_a;
            2'b01:   result = op_b;
            2'b10:   result = op_c;
            2'b11:   result = op_d;
            default: result = {WIDTH{1'b0}};
        endcase
        return result;
    endfunction

    logic [1:0]       sel_s;
    logic [WIDTH-1:0] pick_s;
    logic [WIDTH-1:0] y_r;
    logic             valid_r;
    logic [1:0]       sel_q_r;

    // Form the select code by concatenation. s1 is the MSB; the bits are not ORed.
    assign sel_s = {s1, s0};

    // Combinational selection of the operand addressed by the current code.
    always_comb begin
        pick_s = {WIDTH{1'b0}};
        pick_s = select_operand(sel_s, a, b, c, d);
    end

    // Capture the selected operand, its code and the valid flag.
    // Reset has priority over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_r     <= {WIDTH{1'b0}};
            sel_q_r <= 2'b00;
            valid_r <= 1'b0;
        end else if (en) begin
            y_r     <= pick_s;
            sel_q_r <= sel_s;
            valid_r <= 1'b1;
        end else begin
            y_r     <= y_r;
            sel_q_r <= sel_q_r;
            valid_r <= 1'b0;
        end
    end

    assign y       = y_r;
    assign y_valid = valid_r;
    assign sel_q   = sel_q_r;

`ifdef MUX41_SEL_CHANGE_CNT_EN
    logic [7:0] changes_r;

    // Count enabled edges whose new code differs from the held code.
    // The count saturates at 8'hFF and clears only on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            changes_r <= 8'h00;
        end else if (en && (sel_s != sel_q_r) && (changes_r != 8'hFF)) begin
            changes_r <= changes_r + 8'h01;
        end else begin
            changes_r <= changes_r;
        end
    end

    assign sel_changes = changes_r;
`else
    assign sel_changes = 8'h00;
`endif

endmodule

// File: tb/tb_mux_41.sv
// Directed self-checking bench for mux_41 at WIDTH=1.
// Expected values come from hand-computed constants, plus a small behavioural
// model that is used during the free-running toggle phase and for the
// select-change counter.

`timescale 1ns/1ps

module tb_mux_41;

    logic       clk = 1'b0;
    logic       rst, en, a, b, c, d, s0, s1;
    logic       y, y_valid;
    logic [1:0] sel_q;
    logic [7:0] sel_changes;

    int errors = 0;
    int checks = 0;

    // Model state, updated from the inputs applied before each edge
    logic       m_y;
    logic       m_v;
    logic [1:0] m_sq;
    logic [7:0] m_cnt;

    mux_41 #(.WIDTH(1)) dut (
        .clk(clk), .rst(rst), .en(en),
        .a(a), .b(b), .c(c), .d(d),
        .s0(s0), .s1(s1),
        .y(y), .y_valid(y_valid), .sel_q(sel_q), .sel_changes(sel_changes)
    );

    // 10-unit clock period
    always #5 clk = ~clk;

    `define CHK(tag, obs, exp) \
        begin \
            checks++; \
            assert ((obs) === (exp)) else begin \
                errors++; \
                $error("FAIL %s: observed=%0h expected=%0h", tag, (obs), (exp)); \
            end \
        end

    function automatic logic model_pick(input logic [1:0] code, input logic pa,
                                        input logic pb, input logic pc, input logic pd);
        logic r;
        case (code)
            2'b00:   r = pa;
            2'b01:   r = pb;
            2'b10:   r = pc;
            2'b11:   r = pd;
            default: r = 1'bx;
        endcase
        return r;
    endfunction

    // Advance the model, then advance one clock. Outputs are sampled 1 unit after the edge.
    task automatic tick();
        if (en === 1'b1 && ^{s1, s0} === 1'bx) begin
            errors++;
            $error("FAIL sel_known: observed=%b expected=known", {s1, s0});
        end
        if (rst) begin
            m_y = 1'b0; m_v = 1'b0; m_sq = 2'b00; m_cnt = 8'h00;
        end else if (en) begin
`ifdef MUX41_SEL_CHANGE_CNT_EN
            if ({s1, s0} != m_sq && m_cnt != 8'hFF) m_cnt = m_cnt + 8'h01;
`endif
            m_sq = {s1, s0};
            m_y  = model_pick({s1, s0}, a, b, c, d);
            m_v  = 1'b1;
        end else begin
            m_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] code;
        logic [3:0] sweep_y;

        // Reset: hold rst with every input at 1 and en=1
        rst = 1'b1; en = 1'b1; a = 1'b1; b = 1'b1; c = 1'b1; d = 1'b1; s0 = 1'b1; s1 = 1'b1;
        tick();
        tick();
        `CHK("rst_y", y, 1'b0)
        `CHK("rst_valid", y_valid, 1'b0)
        `CHK("rst_sel_q", sel_q, 2'b00)
        `CHK("rst_cnt", sel_changes, 8'h00)

        // Select sweep: a=0 b=1 c=0 d=1; expected y for codes 0..3 is 0,1,0,1
        rst = 1'b0; a = 1'b0; b = 1'b1; c = 1'b0; d = 1'b1;
        sweep_y = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            code = 2'(i);
            {s1, s0} = code;
            tick();
            `CHK("sweep_y", y, sweep_y[i])
            `CHK("sweep_sel_q", sel_q, code)
            `CHK("sweep_valid", y_valid, 1'b1)
        end
`ifdef MUX41_SEL_CHANGE_CNT_EN
        `CHK("sweep_cnt", sel_changes, 8'h03)
`else
        `CHK("sweep_cnt", sel_changes, 8'h00)
`endif

        // Bit order: s0=1, s1=0 selects b; s0=0, s1=1 selects c
        b = 1'b1; c = 1'b0; s0 = 1'b1; s1 = 1'b0;
        tick();
        `CHK("order_b_y", y, 1'b1)
        `CHK("order_b_sel_q", sel_q, 2'b01)
        s0 = 1'b0; s1 = 1'b1;
        tick();
        `CHK("order_c_y", y, 1'b0)
        `CHK("order_c_sel_q", sel_q, 2'b10)

        // Enable hold: capture d=1 at sel=11, then drop en and switch to a=0 at sel=00
        d = 1'b1; s0 = 1'b1; s1 = 1'b1;
        tick();
        `CHK("hold_cap_y", y, 1'b1)
        `CHK("hold_cap_valid", y_valid, 1'b1)
        en = 1'b0; a = 1'b0; s0 = 1'b0; s1 = 1'b0;
        tick();
        `CHK("hold_y", y, 1'b1)
        `CHK("hold_valid", y_valid, 1'b0)
        `CHK("hold_sel_q", sel_q, 2'b11)
        tick();
        `CHK("hold2_y", y, 1'b1)
`ifdef MUX41_SEL_CHANGE_CNT_EN
        `CHK("hold_cnt", sel_changes, 8'h06)
`else
        `CHK("hold_cnt", sel_changes, 8'h00)
`endif

        // Free-running toggles for 40 cycles, with each signal at a different period
        en = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            a  = 1'(cyc % 2);
            b  = 1'((cyc / 4) % 2);
            c  = 1'((cyc / 5) % 2);
            d  = 1'((cyc / 7) % 2);
            s0 = 1'((cyc / 2) % 2);
            s1 = 1'((cyc / 3) % 2);
            tick();
            `CHK("toggle_y", y, m_y)
            `CHK("toggle_sel_q", sel_q, m_sq)
            `CHK("toggle_valid", y_valid, 1'b1)
        end
        `CHK("toggle_cnt", sel_changes, m_cnt)

        // Toggle s0 for 300 enabled cycles; the counter must saturate and stay there
        s1 = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            s0 = ~s0;
            tick();
        end
`ifdef MUX41_SEL_CHANGE_CNT_EN
        `CHK("sat_cnt", sel_changes, 8'hFF)
`else
        `CHK("sat_cnt", sel_changes, 8'h00)
`endif
        `CHK("sat_cnt_model", sel_changes, m_cnt)

        // A mid-stream reset discards the capture in flight and clears the counter
        rst = 1'b1; d = 1'b1; s0 = 1'b1; s1 = 1'b1;
        tick();
        `CHK("midrst_y", y, 1'b0)
        `CHK("midrst_valid", y_valid, 1'b0)
        `CHK("midrst_sel_q", sel_q, 2'b00)
        `CHK("midrst_cnt", sel_changes, 8'h00)
        rst = 1'b0;
        tick();
        `CHK("post_y", y, 1'b1)
        `CHK("post_valid", y_valid, 1'b1)
        `CHK("post_sel_q", sel_q, 2'b11)
`ifdef MUX41_SEL_CHANGE_CNT_EN
        `CHK("post_cnt", sel_changes, 8'h01)
`else
        `CHK("post_cnt", sel_changes, 8'h00)
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
